// File: rtl/wb_pkg.sv
// Shared encodings and helpers for the second-generation writeback stage.
package wb_pkg;

    // Operand datasize as carried with each uop.
    typedef enum logic [1:0] {
        DS_BYTE  = 2'b00,
        DS_WORD  = 2'b01,
        DS_DWORD = 2'b10,
        DS_RSVD  = 2'b11
    } datasize_e;

    // String-instruction repeat prefix.
    typedef enum logic [1:0] {
        REP_NONE  = 2'b00,
        REP_REP   = 2'b01,
        REP_REPE  = 2'b10,
        REP_REPNE = 2'b11
    } rep_mode_e;

    // REP iteration tracker state.
    typedef enum logic {
        REP_IDLE = 1'b0,
        REP_ITER = 1'b1
    } rep_state_e;

    // Bit positions inside the architectural flags register.
    localparam int FLAG_CF    = 0;
    localparam int FLAG_RSVD1 = 1;
    localparam int FLAG_PF    = 2;
    localparam int FLAG_AF    = 4;
    localparam int FLAG_ZF    = 6;
    localparam int FLAG_SF    = 7;
    localparam int FLAG_DF    = 10;
    localparam int FLAG_OF    = 11;

    // Flags value after reset; bit1 is architecturally always set.
    localparam logic [31:0] FLAG_RST_DEFAULT = 32'h0000_0002;

    // Pointer step for a string element; the reserved size steps like a dword.
    function automatic logic [2:0] str_delta(input logic [1:0] size);
        case (size)
            DS_BYTE: return 3'd1;
            DS_WORD: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_param_if.sv
// Bundle of the WB-stage uop inputs, GPR write outputs and dcache store port.
interface wb_stage_param_if #(
    parameter int DATA_W = 32,
    parameter int NUM_WR = 3
);
    logic                     WB_V;
    logic [DATA_W-1:0]        WB_ALU_RESULT;
    logic [DATA_W-1:0]        WB_COUNT;
    logic [DATA_W-1:0]        WB_STR_POINTER;
    logic [31:0]              WB_ADDRESS;
    logic [1:0]               WB_DATASIZE;
    logic [31:0]              WB_FLAGS;
    logic [31:0]              WB_FLAGS_MASK;
    logic                     WB_LD_FLAGS;
    logic [3*NUM_WR-1:0]      WB_DR;
    logic [NUM_WR-1:0]        WB_LD_GPR;
    logic                     WB_DCACHE_WRITE;
    logic [1:0]               WB_REP_MODE;
    logic                     WB_FIRST_ITER;
    logic                     WB_LAST_UOP;
    logic                     DC_WR_READY;
    logic [3*NUM_WR-1:0]      OUT_DR;
    logic [DATA_W*NUM_WR-1:0] OUT_DR_DATA;
    logic [NUM_WR-1:0]        OUT_LD_GPR;
    logic [31:0]              OUT_FLAGS;
    logic                     OUT_DC_WR_V;
    logic [31:0]              OUT_DC_DATA;
    logic [31:0]              OUT_DC_ADDR;
    logic [1:0]               OUT_DC_SIZE;
    logic                     OUT_REP_TERMINATE;
    logic                     OUT_WB_STALL;

    // Upstream pipeline plus dcache side.
    modport master (
        output WB_V, WB_ALU_RESULT, WB_COUNT, WB_STR_POINTER, WB_ADDRESS,
               WB_DATASIZE, WB_FLAGS, WB_FLAGS_MASK, WB_LD_FLAGS, WB_DR,
               WB_LD_GPR, WB_DCACHE_WRITE, WB_REP_MODE, WB_FIRST_ITER,
               WB_LAST_UOP, DC_WR_READY,
        input  OUT_DR, OUT_DR_DATA, OUT_LD_GPR, OUT_FLAGS, OUT_DC_WR_V,
               OUT_DC_DATA, OUT_DC_ADDR, OUT_DC_SIZE, OUT_REP_TERMINATE,
               OUT_WB_STALL
    );

    // The writeback stage itself.
    modport slave (
        input  WB_V, WB_ALU_RESULT, WB_COUNT, WB_STR_POINTER, WB_ADDRESS,
               WB_DATASIZE, WB_FLAGS, WB_FLAGS_MASK, WB_LD_FLAGS, WB_DR,
               WB_LD_GPR, WB_DCACHE_WRITE, WB_REP_MODE, WB_FIRST_ITER,
               WB_LAST_UOP, DC_WR_READY,
        output OUT_DR, OUT_DR_DATA, OUT_LD_GPR, OUT_FLAGS, OUT_DC_WR_V,
               OUT_DC_DATA, OUT_DC_ADDR, OUT_DC_SIZE, OUT_REP_TERMINATE,
               OUT_WB_STALL
    );
endinterface

// File: rtl/wb_rep_counter.sv
// REP/REPE/REPNE iteration tracking: remaining-count register, loop state and
// the one-cycle termination pulse.
module wb_rep_counter
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_accept,
    input  logic [1:0]        i_mode,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_count,
    input  logic              i_zf_new,
    output logic [DATA_W-1:0] o_cnt_next,
    output logic              o_suppress,
    output logic              o_terminate
);

    rep_state_e        r_state;
    rep_state_e        w_state_next;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] w_cnt_src;
    logic              w_is_rep;
    logic              w_stop;
    logic              w_term;
    logic              r_term;

    // A first-iteration uop always reloads, which also restarts after a flush.
    assign w_is_rep   = (i_mode != REP_NONE);
    assign w_cnt_src  = i_first ? i_count : r_count;
    assign o_cnt_next = i_last ? (w_cnt_src - DATA_W'(1)) : w_cnt_src;
    assign o_suppress = w_is_rep & i_first & (i_count == '0);

    assign w_stop = (o_cnt_next == '0)
                  | ((i_mode == REP_REPE)  & ~i_zf_new)
                  | ((i_mode == REP_REPNE) &  i_zf_new);

    // A zero-count first iteration ends the loop without executing the body.
    assign w_term = i_accept & (o_suppress | (w_is_rep & i_last & w_stop));

    assign o_terminate = r_term;

    // Loop state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= REP_IDLE;
        else     r_state <= w_state_next;
    end

    // Next loop state: termination wins over entering a new loop.
    always_comb begin
        w_state_next = r_state;
        if (w_term)
            w_state_next = REP_IDLE;
        else if (i_accept & w_is_rep & i_first)
            w_state_next = REP_ITER;
    end

    // Remaining-count register, updated by every accepted REP uop.
    always_ff @(posedge CLK) begin
        if (RST)
            r_count <= '0;
        else if (i_accept & w_is_rep)
            r_count <= o_suppress ? '0 : o_cnt_next;
    end

    // Termination pulse, visible the cycle after the deciding uop.
    always_ff @(posedge CLK) begin
        if (RST) r_term <= 1'b0;
        else     r_term <= w_term;
    end

endmodule

// File: rtl/wb_stage_param.sv
// Second-generation writeback stage: GPR write ports, flags merge, string
// pointer advance, REP iteration control and a one-entry dcache store buffer.
module wb_stage_param
    import wb_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NUM_WR   = 3,
    parameter logic [31:0] FLAG_RST = FLAG_RST_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    wb_stage_param_if.slave  bus
);

    logic                  w_stall;
    logic                  w_accept;
    logic                  w_suppress;
    logic                  w_flag_upd;
    logic                  w_capture;
    logic                  w_drain;
    logic                  w_zf_new;
    logic [31:0]           w_flags_merged;
    logic [DATA_W-1:0]     w_delta;
    logic [DATA_W-1:0]     w_ptr;
    logic [DATA_W-1:0]     w_cnt_next;
    logic [3*DATA_W-1:0]   w_port_all;
    logic [31:0]           r_flags;
    logic                  r_buf_v;
    logic [31:0]           r_dc_data;
    logic [31:0]           r_dc_addr;
    logic [1:0]            r_dc_size;

    // A store stalls only while the buffer is occupied and cannot drain.
    assign w_stall  = ~RST & bus.WB_V & bus.WB_DCACHE_WRITE & r_buf_v & ~bus.DC_WR_READY;
    assign w_accept = bus.WB_V & ~w_stall & ~RST;

    assign w_flag_upd     = w_accept & bus.WB_LD_FLAGS & ~w_suppress;
    assign w_flags_merged = (r_flags & ~bus.WB_FLAGS_MASK)
                          | (bus.WB_FLAGS & bus.WB_FLAGS_MASK)
                          | (32'h1 << FLAG_RSVD1);
    // REPE/REPNE look at ZF as it stands after this uop's own merge.
    assign w_zf_new = w_flag_upd ? w_flags_merged[FLAG_ZF] : r_flags[FLAG_ZF];

    // Direction comes from the registered DF, i.e. before this uop's update.
    assign w_delta = DATA_W'(str_delta(bus.WB_DATASIZE));
    assign w_ptr   = r_flags[FLAG_DF] ? (bus.WB_STR_POINTER - w_delta)
                                      : (bus.WB_STR_POINTER + w_delta);

    assign w_capture = w_accept & bus.WB_DCACHE_WRITE & ~w_suppress;
    assign w_drain   = r_buf_v & bus.DC_WR_READY;

    wb_rep_counter #(
        .DATA_W (DATA_W)
    ) u_rep (
        .CLK         (CLK),
        .RST         (RST),
        .i_accept    (w_accept),
        .i_mode      (bus.WB_REP_MODE),
        .i_first     (bus.WB_FIRST_ITER),
        .i_last      (bus.WB_LAST_UOP),
        .i_count     (bus.WB_COUNT),
        .i_zf_new    (w_zf_new),
        .o_cnt_next  (w_cnt_next),
        .o_suppress  (w_suppress),
        .o_terminate (bus.OUT_REP_TERMINATE)
    );

    // Port 0 carries the ALU result, port 1 the advanced pointer, port 2 the count.
    assign w_port_all = {w_cnt_next, w_ptr, bus.WB_ALU_RESULT};

    assign bus.OUT_DR       = RST ? '0 : bus.WB_DR;
    assign bus.OUT_DR_DATA  = RST ? '0 : w_port_all[DATA_W*NUM_WR-1:0];
    assign bus.OUT_LD_GPR   = {NUM_WR{w_accept & ~w_suppress}} & bus.WB_LD_GPR;
    assign bus.OUT_WB_STALL = w_stall;
    assign bus.OUT_FLAGS    = r_flags;
    assign bus.OUT_DC_WR_V  = r_buf_v;
    assign bus.OUT_DC_DATA  = r_dc_data;
    assign bus.OUT_DC_ADDR  = r_dc_addr;
    assign bus.OUT_DC_SIZE  = r_dc_size;

    // Architectural flags with per-flag merge.
    always_ff @(posedge CLK) begin
        if (RST)
            r_flags <= FLAG_RST | (32'h1 << FLAG_RSVD1);
        else if (w_flag_upd)
            r_flags <= w_flags_merged;
    end

    // Store buffer occupancy: a capture refills even while draining.
    always_ff @(posedge CLK) begin
        if (RST)
            r_buf_v <= 1'b0;
        else if (w_capture)
            r_buf_v <= 1'b1;
        else if (w_drain)
            r_buf_v <= 1'b0;
    end

    // Store buffer payload; meaningful only while the buffer is valid.
    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_dc_data <= 32'(bus.WB_ALU_RESULT);
            r_dc_addr <= bus.WB_ADDRESS;
            r_dc_size <= bus.WB_DATASIZE;
        end
    end

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed self-checking bench for wb_stage_param.
module tb_wb_stage_param;
    import wb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_stage_param_if #(.DATA_W(32), .NUM_WR(3)) bus ();

    wb_stage_param #(
        .DATA_W   (32),
        .NUM_WR   (3),
        .FLAG_RST (32'h0000_0002)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.WB_V            = 1'b0;
        bus.WB_ALU_RESULT   = '0;
        bus.WB_COUNT        = '0;
        bus.WB_STR_POINTER  = '0;
        bus.WB_ADDRESS      = '0;
        bus.WB_DATASIZE     = 2'b00;
        bus.WB_FLAGS        = '0;
        bus.WB_FLAGS_MASK   = '0;
        bus.WB_LD_FLAGS     = 1'b0;
        bus.WB_DR           = '0;
        bus.WB_LD_GPR       = '0;
        bus.WB_DCACHE_WRITE = 1'b0;
        bus.WB_REP_MODE     = 2'b00;
        bus.WB_FIRST_ITER   = 1'b0;
        bus.WB_LAST_UOP     = 1'b0;
        bus.DC_WR_READY     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        failures = 0;
        idle_in();

        // Reset: a valid store-writing uop must be fully masked.
        bus.WB_V = 1'b1;
        bus.WB_LD_GPR = 3'b111;
        bus.WB_DCACHE_WRITE = 1'b1;
        tick();
        tick();
        chk("rst_flags", bus.OUT_FLAGS, 32'h2);
        chk("rst_bufv", 32'(bus.OUT_DC_WR_V), 32'h0);
        chk("rst_term", 32'(bus.OUT_REP_TERMINATE), 32'h0);
        chk("rst_ldgpr", 32'(bus.OUT_LD_GPR), 32'h0);
        chk("rst_stall", 32'(bus.OUT_WB_STALL), 32'h0);
        rst = 1'b0;
        idle_in();
        tick();

        // Flag merge: only ZF and CF affected; bit1 stays set.
        bus.WB_V = 1'b1;
        bus.WB_LD_FLAGS = 1'b1;
        bus.WB_FLAGS = 32'hFFFF_FFFF;
        bus.WB_FLAGS_MASK = 32'h0000_0041;
        bus.WB_LD_GPR = 3'b001;
        bus.WB_ALU_RESULT = 32'h0000_1234;
        bus.WB_DR = 9'b010_001_011;
        #1;
        chk("gpr_ld", 32'(bus.OUT_LD_GPR), 32'h1);
        chk("gpr_port0", bus.OUT_DR_DATA[31:0], 32'h0000_1234);
        chk("gpr_dr", 32'(bus.OUT_DR), 32'h0000_008B);
        tick();
        chk("flag_merge", bus.OUT_FLAGS, 32'h0000_0043);
        bus.WB_FLAGS_MASK = 32'h0;
        tick();
        chk("flag_nomask", bus.OUT_FLAGS, 32'h0000_0043);

        // Pointer: this uop sets DF but still advances with the old DF=0.
        bus.WB_FLAGS = 32'h0000_0400;
        bus.WB_FLAGS_MASK = 32'h0000_0400;
        bus.WB_DATASIZE = 2'b10;
        bus.WB_STR_POINTER = 32'h0000_0100;
        #1;
        chk("ptr_inc_dword", bus.OUT_DR_DATA[63:32], 32'h0000_0104);
        tick();
        chk("flag_df_set", bus.OUT_FLAGS, 32'h0000_0443);
        bus.WB_LD_FLAGS = 1'b0;
        bus.WB_DATASIZE = 2'b01;
        bus.WB_STR_POINTER = 32'h0000_0001;
        #1;
        chk("ptr_dec_wrap", bus.OUT_DR_DATA[63:32], 32'hFFFF_FFFF);
        bus.WB_DATASIZE = 2'b11;
        bus.WB_STR_POINTER = 32'h0000_0010;
        #1;
        chk("ptr_dec_rsvd", bus.OUT_DR_DATA[63:32], 32'h0000_000C);
        bus.WB_LD_FLAGS = 1'b1;
        bus.WB_FLAGS = 32'h0;
        bus.WB_FLAGS_MASK = 32'h0000_0400;
        tick();
        chk("flag_df_clr", bus.OUT_FLAGS, 32'h0000_0043);

        // REPNE, count 3: ends when ZF becomes 1 on iteration 2's last uop.
        idle_in();
        bus.WB_V = 1'b1;
        bus.WB_REP_MODE = 2'b11;
        bus.WB_COUNT = 32'd3;
        bus.WB_FIRST_ITER = 1'b1;
        bus.WB_LD_FLAGS = 1'b1;
        bus.WB_FLAGS_MASK = 32'h0000_0040;
        bus.WB_FLAGS = 32'h0;
        bus.WB_LD_GPR = 3'b110;
        #1;
        chk("rep_i1a_cnt", bus.OUT_DR_DATA[95:64], 32'd3);
        chk("rep_i1a_ld", 32'(bus.OUT_LD_GPR), 32'h6);
        tick();
        chk("rep_i1a_term", 32'(bus.OUT_REP_TERMINATE), 32'h0);
        chk("rep_i1a_flags", bus.OUT_FLAGS, 32'h0000_0003);
        bus.WB_LAST_UOP = 1'b1;
        #1;
        chk("rep_i1b_cnt", bus.OUT_DR_DATA[95:64], 32'd2);
        tick();
        chk("rep_i1b_term", 32'(bus.OUT_REP_TERMINATE), 32'h0);
        bus.WB_FIRST_ITER = 1'b0;
        bus.WB_LAST_UOP = 1'b0;
        bus.WB_COUNT = 32'd99;
        #1;
        chk("rep_i2a_cnt", bus.OUT_DR_DATA[95:64], 32'd2);
        tick();
        bus.WB_LAST_UOP = 1'b1;
        bus.WB_FLAGS = 32'h0000_0040;
        #1;
        chk("rep_i2b_cnt", bus.OUT_DR_DATA[95:64], 32'd1);
        tick();
        chk("rep_term_pulse", 32'(bus.OUT_REP_TERMINATE), 32'h1);
        chk("rep_flags", bus.OUT_FLAGS, 32'h0000_0043);
        chk("rep_state_idle", 32'(dut.u_rep.r_state), 32'(REP_IDLE));
        idle_in();
        tick();
        chk("rep_term_end", 32'(bus.OUT_REP_TERMINATE), 32'h0);

        // Zero-count REP: all effects suppressed, termination still pulses.
        bus.WB_V = 1'b1;
        bus.WB_REP_MODE = 2'b01;
        bus.WB_FIRST_ITER = 1'b1;
        bus.WB_LAST_UOP = 1'b1;
        bus.WB_COUNT = 32'd0;
        bus.WB_LD_GPR = 3'b001;
        bus.WB_DCACHE_WRITE = 1'b1;
        bus.WB_LD_FLAGS = 1'b1;
        bus.WB_FLAGS_MASK = 32'hFFFF_FFFF;
        bus.WB_FLAGS = 32'h0;
        #1;
        chk("zc_ldgpr", 32'(bus.OUT_LD_GPR), 32'h0);
        tick();
        chk("zc_bufv", 32'(bus.OUT_DC_WR_V), 32'h0);
        chk("zc_term", 32'(bus.OUT_REP_TERMINATE), 32'h1);
        chk("zc_flags", bus.OUT_FLAGS, 32'h0000_0043);
        chk("zc_state", 32'(dut.u_rep.r_state), 32'(REP_IDLE));
        idle_in();
        tick();
        chk("zc_term_end", 32'(bus.OUT_REP_TERMINATE), 32'h0);

        // Store handshake: second store stalls, then drain+capture together.
        bus.WB_V = 1'b1;
        bus.WB_DCACHE_WRITE = 1'b1;
        bus.WB_LD_GPR = 3'b001;
        bus.WB_ALU_RESULT = 32'hAAAA_0001;
        bus.WB_ADDRESS = 32'h0000_1000;
        bus.WB_DATASIZE = 2'b10;
        #1;
        chk("st1_stall", 32'(bus.OUT_WB_STALL), 32'h0);
        chk("st1_ld", 32'(bus.OUT_LD_GPR), 32'h1);
        tick();
        chk("st1_bufv", 32'(bus.OUT_DC_WR_V), 32'h1);
        chk("st1_data", bus.OUT_DC_DATA, 32'hAAAA_0001);
        chk("st1_addr", bus.OUT_DC_ADDR, 32'h0000_1000);
        chk("st1_size", 32'(bus.OUT_DC_SIZE), 32'h2);
        bus.WB_ALU_RESULT = 32'hBBBB_0002;
        bus.WB_ADDRESS = 32'h0000_2000;
        bus.WB_DATASIZE = 2'b01;
        #1;
        chk("st2_stall", 32'(bus.OUT_WB_STALL), 32'h1);
        chk("st2_ld_blocked", 32'(bus.OUT_LD_GPR), 32'h0);
        tick();
        chk("st2_hold_data", bus.OUT_DC_DATA, 32'hAAAA_0001);
        chk("st2_hold_v", 32'(bus.OUT_DC_WR_V), 32'h1);
        bus.DC_WR_READY = 1'b1;
        #1;
        chk("st2_nostall", 32'(bus.OUT_WB_STALL), 32'h0);
        tick();
        chk("st2_bufv", 32'(bus.OUT_DC_WR_V), 32'h1);
        chk("st2_data", bus.OUT_DC_DATA, 32'hBBBB_0002);
        chk("st2_addr", bus.OUT_DC_ADDR, 32'h0000_2000);
        chk("st2_size", 32'(bus.OUT_DC_SIZE), 32'h1);
        idle_in();
        bus.DC_WR_READY = 1'b1;
        tick();
        chk("st_drained", 32'(bus.OUT_DC_WR_V), 32'h0);

        // Reset in the middle of a REP loop with the store buffer full.
        idle_in();
        bus.WB_V = 1'b1;
        bus.WB_REP_MODE = 2'b01;
        bus.WB_FIRST_ITER = 1'b1;
        bus.WB_COUNT = 32'd5;
        bus.WB_DCACHE_WRITE = 1'b1;
        bus.WB_ALU_RESULT = 32'hCCCC_0003;
        tick();
        chk("mr_bufv", 32'(bus.OUT_DC_WR_V), 32'h1);
        chk("mr_state_iter", 32'(dut.u_rep.r_state), 32'(REP_ITER));
        bus.WB_FIRST_ITER = 1'b0;
        bus.WB_LAST_UOP = 1'b1;
        bus.WB_COUNT = 32'd0;
        #1;
        chk("mr_cnt_reg", bus.OUT_DR_DATA[95:64], 32'd4);
        chk("mr_stall", 32'(bus.OUT_WB_STALL), 32'h1);
        rst = 1'b1;
        #1;
        chk("mr_stall_rst", 32'(bus.OUT_WB_STALL), 32'h0);
        tick();
        chk("mr_bufv_rst", 32'(bus.OUT_DC_WR_V), 32'h0);
        chk("mr_flags_rst", bus.OUT_FLAGS, 32'h2);
        chk("mr_term_rst", 32'(bus.OUT_REP_TERMINATE), 32'h0);
        chk("mr_state_rst", 32'(dut.u_rep.r_state), 32'(REP_IDLE));
        rst = 1'b0;
        idle_in();
        tick();
        chk("mr_term_after", 32'(bus.OUT_REP_TERMINATE), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
Parametrised second-generation writeback stage for the pipelined x86 core. Adds the behaviour the first-generation stage only stubs:
- architectural flags register with per-flag merge
- REP/REPE/REPNE iteration counter with termination detection
- DF-directed string-pointer update
- one-entry registered store buffer with a ready handshake to the dcache

Drives up to three GPR write ports into REG_FILE32.

Parameters:
DATA_W, 32, width of GPR data, count and pointer paths
NUM_WR, 3, number of GPR write ports (legal 1..3)
FLAG_RST, 32'h0000_0002, flags reset value (bit1 always reads 1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
WB_V  in  1  uop in WB is valid
WB_ALU_RESULT  in  DATA_W  EX result; port0 data and store data
WB_COUNT  in  DATA_W  ECX value, used on first REP iteration
WB_STR_POINTER  in  DATA_W  ESI/EDI value to advance
WB_ADDRESS  in  32  store address
WB_DATASIZE  in  2  00 byte, 01 word, 10 dword
WB_FLAGS  in  32  flags produced by EX
WB_FLAGS_MASK  in  32  1 = flag affected by this uop
WB_LD_FLAGS  in  1  uop writes flags
WB_DR  in  3*NUM_WR  destination register per port
WB_LD_GPR  in  NUM_WR  write enable per port
WB_DCACHE_WRITE  in  1  uop stores to memory
WB_REP_MODE  in  2  00 none, 01 REP, 10 REPE, 11 REPNE
WB_FIRST_ITER  in  1  uop belongs to first iteration
WB_LAST_UOP  in  1  last uop of an iteration
DC_WR_READY  in  1  dcache accepts store this cycle
OUT_DR  out  3*NUM_WR  destination per port
OUT_DR_DATA  out  DATA_W*NUM_WR  port0 ALU result, port1 updated pointer, port2 next count
OUT_LD_GPR  out  NUM_WR  qualified write enables
OUT_FLAGS  out  32  architectural flags register
OUT_DC_WR_V  out  1  store buffer valid
OUT_DC_DATA  out  32  buffered store data
OUT_DC_ADDR  out  32  buffered store address
OUT_DC_SIZE  out  2  buffered datasize
OUT_REP_TERMINATE  out  1  one-cycle pulse: REP loop ends
OUT_WB_STALL  out  1  WB cannot accept uop

Behaviour:
- Reset (RST sampled high at CLK edge):
  - OUT_FLAGS=FLAG_RST; buffer valid=0 (a pending store is dropped); FSM=IDLE; count=0; OUT_REP_TERMINATE=0.
  - All combinational outputs are qualified by !RST.
- Stall and accept:
  - OUT_WB_STALL = WB_V & WB_DCACHE_WRITE & buf_v & !DC_WR_READY.
  - accept = WB_V & !OUT_WB_STALL & !RST.
- GPR writes:
  - OUT_LD_GPR[k] = accept & WB_LD_GPR[k] & !suppress. Same cycle, no register.
  - OUT_DR passes WB_DR through.
- Flags:
  - On accept & WB_LD_FLAGS & !suppress: flags <= (flags & ~MASK) | (WB_FLAGS & MASK); bit1 forced to 1.
  - Bit positions: OF11, DF10, SF7, ZF6, AF4, PF2, CF0.
- Pointer:
  - delta = 1/2/4 for datasize 00/01/10; encoding 11 is treated as 4.
  - ptr = WB_STR_POINTER + delta if registered DF=0, else minus delta; modulo 2^DATA_W.
  - DF is the value before this uop's flag update.
- Count source: cnt_src = WB_FIRST_ITER ? WB_COUNT : count_reg; cnt_next = cnt_src - 1 on last uop, else cnt_src.
- REP FSM, states IDLE/ITER:
  - IDLE -> ITER on accept, REP_MODE!=0, FIRST_ITER, WB_COUNT!=0.
  - count_reg <= cnt_next on every accepted REP uop.
  - Termination condition on accept & LAST_UOP in a REP uop: cnt_next==0, or REPE & zf_new==0, or REPNE & zf_new==1.
    - zf_new is ZF after this uop's merge.
    - On termination: -> IDLE; OUT_REP_TERMINATE pulses the next cycle.
  - Zero-count first iteration (FIRST_ITER & WB_COUNT==0):
    - suppress=1: GPR, flag and store effects are discarded.
    - Terminate pulse next cycle; remain IDLE.
  - FIRST_ITER seen while in ITER: reload from WB_COUNT (restart after flush).
- Store buffer (latency 1):
  - On accept & DCACHE_WRITE & !suppress, capture {ALU_RESULT, ADDRESS, DATASIZE}; buf_v=1.
  - Drain when buf_v & DC_WR_READY.
  - Drain and capture in the same cycle: buffer holds the new store, buf_v stays 1, no stall.
  - Drain without capture: buf_v=0.
- Invalid uop (WB_V=0): no state changes except buffer drain.

Decomposition:
- Package wb_pkg:
  - datasize and REP-mode encodings
  - flag bit indices
  - FLAG_RST
  - delta-by-datasize function
- Sub-module wb_rep_counter: FSM, count register, termination pulse. Inputs are accept, mode, first/last, WB_COUNT, zf_new; outputs are cnt_next, suppress, terminate.

Test Plan:
- Flag merge: reset, then accept WB_FLAGS=0xFFFFFFFF with MASK=0x00000041 -> OUT_FLAGS=0x00000043; next uop MASK=0 -> unchanged.
- Pointer: DF=1, datasize=01, pointer 0x00000001 -> port1 data 0xFFFFFFFF; DF=0, size 10, pointer 0x100 -> 0x104.
- REPNE: COUNT=3, ZF=0 results on iterations 1-2, ZF=1 on iteration 2 last uop -> terminate pulse after iteration 2, port2 data=1, FSM IDLE.
- Zero count: REP, FIRST_ITER, COUNT=0, LD_GPR=1, DCACHE_WRITE=1 -> OUT_LD_GPR=0, no buffer capture, terminate pulse next cycle.
- Store handshake: two back-to-back stores with DC_WR_READY=0 -> second is stalled; raise READY -> first drains while second is captured in the same cycle, no bubble.
- Reset mid-REP with buffer full -> next cycle OUT_DC_WR_V=0, OUT_FLAGS=0x2, no terminate pulse.
